// File: rtl/i2c_req_arbiter_if.sv
// rtl/i2c_req_arbiter_if.sv - requester, I2C master and response signals of the two-port arbiter
interface i2c_req_arbiter_if;
   logic       req0_valid;
   logic       req0_ready;
   logic [6:0] req0_addr;
   logic [7:0] req0_data;
   logic       req0_rw;
   logic       req1_valid;
   logic       req1_ready;
   logic [6:0] req1_addr;
   logic [7:0] req1_data;
   logic       req1_rw;
   logic       m_start;
   logic [6:0] m_addr;
   logic [7:0] m_data;
   logic       m_rw;
   logic       m_busy;
   logic [7:0] m_rdata;
   logic       rsp_valid;
   logic       rsp_id;
   logic [7:0] rsp_data;
   logic       rsp_err;

   // master: the arbiter itself; slave: requesters, i2c_master_top and response sink
   modport master (
      input  req0_valid, req0_addr, req0_data, req0_rw,
      input  req1_valid, req1_addr, req1_data, req1_rw,
      output req0_ready, req1_ready,
      output m_start, m_addr, m_data, m_rw,
      input  m_busy, m_rdata,
      output rsp_valid, rsp_id, rsp_data, rsp_err
   );

   modport slave (
      output req0_valid, req0_addr, req0_data, req0_rw,
      output req1_valid, req1_addr, req1_data, req1_rw,
      input  req0_ready, req1_ready,
      input  m_start, m_addr, m_data, m_rw,
      output m_busy, m_rdata,
      input  rsp_valid, rsp_id, rsp_data, rsp_err
   );
endinterface

// File: rtl/i2c_req_arbiter.sv
// rtl/i2c_req_arbiter.sv - round-robin arbiter sharing one I2C master between two requesters
module i2c_req_arbiter #(
   parameter int START_PULSE    = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input logic               clk,
   input logic               reset,
   i2c_req_arbiter_if.master bus
);
   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_BUSY,
      WAIT_DONE,
      RESP
   } state_t;

   localparam logic [7:0]  START_LAST = 8'(START_PULSE - 1);
   localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [7:0]  start_cnt;
   logic [15:0] tmo_cnt;
   logic        last_grant;
   logic        grant_id;
   logic        grant0;
   logic        grant1;

   // Contention goes to the requester not served last; ready is held low in reset.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (reset && state == IDLE) begin
         if (bus.req0_valid && (!bus.req1_valid || last_grant))
            grant0 = 1'b1;
         else if (bus.req1_valid)
            grant1 = 1'b1;
      end
   end

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         start_cnt     <= 8'd0;
         tmo_cnt       <= 16'd0;
         last_grant    <= 1'b1;
         grant_id      <= 1'b0;
         bus.m_start   <= 1'b0;
         bus.m_addr    <= 7'd0;
         bus.m_data    <= 8'd0;
         bus.m_rw      <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_id    <= 1'b0;
         bus.rsp_data  <= 8'd0;
         bus.rsp_err   <= 1'b0;
      end else begin
         bus.rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  bus.m_addr  <= grant1 ? bus.req1_addr : bus.req0_addr;
                  bus.m_data  <= grant1 ? bus.req1_data : bus.req0_data;
                  bus.m_rw    <= grant1 ? bus.req1_rw   : bus.req0_rw;
                  grant_id    <= grant1;
                  last_grant  <= grant1;
                  bus.m_start <= 1'b1;
                  start_cnt   <= 8'd0;
                  state       <= START;
               end
            end
            START: begin
               if (start_cnt == START_LAST) begin
                  bus.m_start <= 1'b0;
                  tmo_cnt     <= 16'd0;
                  state       <= WAIT_BUSY;
               end else begin
                  start_cnt <= start_cnt + 8'd1;
               end
            end
            WAIT_BUSY: begin
               if (bus.m_busy) begin
                  tmo_cnt <= 16'd0;
                  state   <= WAIT_DONE;
               end else if (tmo_cnt == TMO_LAST) begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_id    <= grant_id;
                  bus.rsp_data  <= 8'd0;
                  bus.rsp_err   <= 1'b1;
                  state         <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end
            WAIT_DONE: begin
               if (!bus.m_busy) begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_id    <= grant_id;
                  bus.rsp_data  <= bus.m_rw ? bus.m_rdata : 8'd0;
                  bus.rsp_err   <= 1'b0;
                  state         <= RESP;
               end else if (tmo_cnt == TMO_LAST) begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_id    <= grant_id;
                  bus.rsp_data  <= 8'd0;
                  bus.rsp_err   <= 1'b1;
                  state         <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb/tb_i2c_req_arbiter.sv - directed vector bench for i2c_req_arbiter
module tb_i2c_req_arbiter;
   localparam int SP  = 8;
   localparam int TMO = 300;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   dbl_cnt;

   i2c_req_arbiter_if bus();

   i2c_req_arbiter #(.START_PULSE(SP), .TIMEOUT_CYCLES(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.req0_ready && bus.req1_ready) dbl_cnt = dbl_cnt + 1;
   end

   // mode: 0 = normal busy pulse, 1 = busy never rises, 2 = busy stuck high
   typedef struct {
      logic       id;
      logic [6:0] addr;
      logic [7:0] data;
      logic       rw;
      int         mode;
      int         busy_len;
      logic [7:0] rdata;
      logic [7:0] exp_data;
      logic       exp_err;
      int         exp_lat;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_req(input logic id, input logic v, input logic [6:0] a,
                            input logic [7:0] d, input logic rw);
      if (id) begin
         bus.req1_valid = v; bus.req1_addr = a; bus.req1_data = d; bus.req1_rw = rw;
      end else begin
         bus.req0_valid = v; bus.req0_addr = a; bus.req0_data = d; bus.req0_rw = rw;
      end
   endtask

   // Called on the negedge right after the accepting edge.
   task automatic serve(input int mode, input int busy_len, input logic [7:0] rdata,
                        output int start_len, output int lat);
      start_len = 0;
      while (bus.m_start && start_len < 300) begin
         start_len++;
         @(negedge clk);
      end
      lat = 0;
      if (mode == 0) begin
         repeat (3) @(negedge clk);
         bus.m_busy = 1'b1;
         repeat (busy_len) @(negedge clk);
         bus.m_rdata = rdata;
         bus.m_busy  = 1'b0;
      end else if (mode == 2) begin
         bus.m_rdata = rdata;
         bus.m_busy  = 1'b1;
      end
      while (!bus.rsp_valid && lat < TMO + 50) begin
         @(negedge clk);
         lat++;
      end
      bus.m_busy = 1'b0;
   endtask

   task automatic wait_ready(input logic id, output int n);
      n = 0;
      #1;
      while (!(id ? bus.req1_ready : bus.req0_ready) && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
   endtask

   initial begin
      int   n;
      int   sl;
      int   lat;
      logic g;

      vecs[0] = '{1'b0, 7'h02, 8'h2F, 1'b0, 0, 200, 8'hAA, 8'h00, 1'b0, 0};
      vecs[1] = '{1'b1, 7'h02, 8'h2F, 1'b1, 0, 20,  8'hF0, 8'hF0, 1'b0, 0};
      vecs[2] = '{1'b0, 7'h7F, 8'hFF, 1'b1, 0, 5,   8'h5A, 8'h5A, 1'b0, 0};
      vecs[3] = '{1'b1, 7'h55, 8'h00, 1'b0, 1, 0,   8'h00, 8'h00, 1'b1, TMO};
      vecs[4] = '{1'b0, 7'h11, 8'h22, 1'b1, 2, 0,   8'h99, 8'h00, 1'b1, TMO + 1};

      checks  = 0;
      errors  = 0;
      dbl_cnt = 0;
      reset   = 1'b0;
      bus.m_busy  = 1'b0;
      bus.m_rdata = 8'h00;
      drive_req(1'b0, 1'b1, 7'h01, 8'h01, 1'b1);
      drive_req(1'b1, 1'b1, 7'h02, 8'h02, 1'b1);
      repeat (3) @(negedge clk);
      check("rst_ready0", 32'(bus.req0_ready), 0);
      check("rst_ready1", 32'(bus.req1_ready), 0);
      check("rst_outputs", {bus.m_start, bus.m_addr, bus.m_data, bus.m_rw, bus.rsp_valid,
                            bus.rsp_id, bus.rsp_data, bus.rsp_err}, 0);
      drive_req(1'b0, 1'b0, 7'h00, 8'h00, 1'b0);
      drive_req(1'b1, 1'b0, 7'h00, 8'h00, 1'b0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         drive_req(vecs[i].id, 1'b1, vecs[i].addr, vecs[i].data, vecs[i].rw);
         wait_ready(vecs[i].id, n);
         check($sformatf("v%0d_ready", i), 32'(n < 20), 1);
         check($sformatf("v%0d_other_ready", i),
               32'(vecs[i].id ? bus.req0_ready : bus.req1_ready), 0);
         @(posedge clk);
         @(negedge clk);
         drive_req(vecs[i].id, 1'b0, ~vecs[i].addr, ~vecs[i].data, ~vecs[i].rw);
         #1;
         check($sformatf("v%0d_mfields", i), {bus.m_addr, bus.m_data, bus.m_rw},
               {vecs[i].addr, vecs[i].data, vecs[i].rw});
         serve(vecs[i].mode, vecs[i].busy_len, vecs[i].rdata, sl, lat);
         check($sformatf("v%0d_start_len", i), 32'(sl), SP);
         check($sformatf("v%0d_rsp_valid", i), 32'(bus.rsp_valid), 1);
         check($sformatf("v%0d_rsp", i), {bus.rsp_id, bus.rsp_data, bus.rsp_err},
               {vecs[i].id, vecs[i].exp_data, vecs[i].exp_err});
         if (vecs[i].exp_lat != 0)
            check($sformatf("v%0d_tmo_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
         @(negedge clk);
         check($sformatf("v%0d_rsp_pulse", i), 32'(bus.rsp_valid), 0);
         check($sformatf("v%0d_rsp_hold", i), {bus.m_start, bus.rsp_id, bus.rsp_data, bus.rsp_err},
               {1'b0, vecs[i].id, vecs[i].exp_data, vecs[i].exp_err});
         check($sformatf("v%0d_mfields_hold", i), {bus.m_addr, bus.m_data, bus.m_rw},
               {vecs[i].addr, vecs[i].data, vecs[i].rw});
      end

      // Contention right after reset: req0 must win first, then alternate.
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      dbl_cnt = 0;
      drive_req(1'b0, 1'b1, 7'h10, 8'h01, 1'b0);
      drive_req(1'b1, 1'b1, 7'h20, 8'h02, 1'b1);
      for (int k = 0; k < 4; k++) begin
         n = 0;
         #1;
         while (!(bus.req0_ready || bus.req1_ready) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
         end
         check($sformatf("cont%0d_ready", k), 32'(n < 20), 1);
         g = bus.req1_ready;
         check($sformatf("cont%0d_grant", k), 32'(g), 32'(k % 2));
         @(posedge clk);
         @(negedge clk);
         check($sformatf("cont%0d_maddr", k), 32'(bus.m_addr), (k % 2 == 1) ? 32'h20 : 32'h10);
         serve(0, 5, 8'(8'h30 + k), sl, lat);
         check($sformatf("cont%0d_rsp", k), {bus.rsp_valid, bus.rsp_id, bus.rsp_data},
               {1'b1, (k % 2 == 1), (k % 2 == 1) ? 8'(8'h30 + k) : 8'h00});
         @(negedge clk);
      end
      check("cont_no_double_ready", 32'(dbl_cnt), 0);
      drive_req(1'b0, 1'b0, 7'h00, 8'h00, 1'b0);
      drive_req(1'b1, 1'b0, 7'h00, 8'h00, 1'b0);
      repeat (2) @(negedge clk);

      // Reset while waiting for the master to finish.
      drive_req(1'b0, 1'b1, 7'h33, 8'h44, 1'b1);
      wait_ready(1'b0, n);
      check("rwd_ready", 32'(n < 20), 1);
      @(posedge clk);
      @(negedge clk);
      n = 0;
      while (bus.m_start && n < 300) begin
         @(negedge clk);
         n++;
      end
      bus.m_busy = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rwd_outputs", {bus.m_start, bus.m_addr, bus.m_data, bus.m_rw, bus.rsp_valid,
                            bus.rsp_id, bus.rsp_data, bus.rsp_err}, 0);
      check("rwd_ready_in_reset", 32'(bus.req0_ready), 0);
      bus.m_busy = 1'b0;
      @(negedge clk);
      check("rwd_no_rsp", 32'(bus.rsp_valid), 0);
      reset = 1'b1;
      #1;
      check("rwd_post_ready", 32'(bus.req0_ready), 1);
      @(posedge clk);
      @(negedge clk);
      check("rwd_rsp_after_reset", 32'(bus.rsp_valid), 0);
      check("rwd_maddr", {bus.m_addr, bus.m_data}, {7'h33, 8'h44});
      drive_req(1'b0, 1'b0, 7'h00, 8'h00, 1'b0);
      serve(0, 4, 8'h77, sl, lat);
      check("rwd_start_len", 32'(sl), SP);
      check("rwd_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err},
            {1'b1, 1'b0, 8'h77, 1'b0});
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 Parameter START_PULSE, default 8: clk cycles m_start is held high per transaction (range 1-255).
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: max clk cycles spent in WAIT_BUSY or in WAIT_DONE before abort (range 2-65535).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req0_valid / req1_valid  input  1  requester 0/1 has a transaction pending.
REQ-006 req0_ready / req1_ready  output  1  arbiter accepts requester 0/1 this cycle.
REQ-007 req0_addr / req1_addr  input  7  target slave address.
REQ-008 req0_data / req1_data  input  8  write data or memory address byte.
REQ-009 req0_rw / req1_rw  input  1  0 = write, 1 = read.
REQ-010 m_start  output  1  start strobe to i2c_master_top.
REQ-011 m_addr / m_data / m_rw  output  7 / 8 / 1  transaction fields to i2c_master_top.
REQ-012 m_busy  input  1  master transaction in progress.
REQ-013 m_rdata  input  8  master read byte, valid when m_busy falls.
REQ-014 rsp_valid  output  1  one-cycle completion pulse.
REQ-015 rsp_id  output  1  requester index of completed transaction.
REQ-016 rsp_data  output  8  read byte; 0x00 for writes and errors.
REQ-017 rsp_err  output  1  transaction aborted by timeout.

Function
REQ-018 FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, RESP; exactly one active.
REQ-019 IDLE: reqN_ready is combinational; at most one asserted per cycle; both low outside IDLE.
REQ-020 Arbitration: only one valid -> grant it; both valid -> grant index != last_grant (round-robin).
REQ-021 Accept = reqN_valid && reqN_ready: latch addr/data/rw into m_addr/m_data/m_rw, record grant id, set last_grant, go to START next cycle.
REQ-022 m_addr/m_data/m_rw hold latched values from accept until next accept; requester inputs changing after accept are ignored.
REQ-023 START: m_start high for exactly START_PULSE cycles (accept at cycle T -> high T+1..T+START_PULSE), then WAIT_BUSY.
REQ-024 WAIT_BUSY: m_busy=1 -> WAIT_DONE; timeout counter cleared on entry.
REQ-025 WAIT_DONE: m_busy=0 -> sample m_rdata (if m_rw=1, else 0x00) into rsp_data, rsp_err=0, go to RESP; timeout counter cleared on entry.
REQ-026 Timeout: counter reaching TIMEOUT_CYCLES-1 in WAIT_BUSY or WAIT_DONE -> RESP with rsp_err=1, rsp_data=0x00.
REQ-027 RESP: rsp_valid high exactly one cycle with rsp_id/rsp_data/rsp_err stable; next state IDLE; rsp_id/rsp_data/rsp_err hold until next RESP.
REQ-028 No back-to-back accept: minimum one IDLE cycle between RESP and next accept.
REQ-029 m_busy rising while in START is ignored; WAIT_BUSY entered with m_busy already 1 exits next cycle.
REQ-030 m_busy timeout-abort leaves m_start low; arbiter does not retry.

Reset
REQ-031 reset=0 at a rising edge: state IDLE, m_start=0, m_addr=0, m_data=0, m_rw=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, counters=0, last_grant=1 (req0 wins first contention).
REQ-032 Reset mid-transaction (any state) aborts without rsp_valid; m_start low from the next cycle.
REQ-033 reqN_ready = 0 while reset=0.

Verification
REQ-034 Single write: req0 addr=0x02 data=0x2F rw=0; model asserts m_busy 3 cycles after m_start falls for 200 cycles -> m_start high 8 cycles, rsp_valid with id=0, data=0x00, err=0.
REQ-035 Read: req1 addr=0x02 data=0x2F rw=1, m_rdata=0xF0 when busy falls -> rsp_id=1, rsp_data=0xF0, rsp_err=0.
REQ-036 Contention: req0/req1 valid continuously, 4 transactions -> grant order 0,1,0,1; no double ready in any cycle.
REQ-037 Timeout: m_busy held 0 -> rsp_err=1, rsp_data=0x00 exactly TIMEOUT_CYCLES cycles after WAIT_BUSY entry; m_busy stuck 1 -> same from WAIT_DONE.
REQ-038 Reset asserted in WAIT_DONE -> no rsp_valid, all outputs at reset values next cycle, next req0 accepted after reset release.
